// File: rtl/game_sprite_control_pkg.sv
// Shared configuration for the game sprite blocks: default widths and
// screen/sprite geometry used by the sprite responders and their interface.
package game_sprite_control_pkg;

   localparam int DEF_X_WIDTH       = 11;
   localparam int DEF_Y_WIDTH       = 10;
   localparam int DEF_D_WIDTH       = 4;
   localparam int DEF_SCREEN_WIDTH  = 640;
   localparam int DEF_SCREEN_HEIGHT = 480;
   localparam int DEF_SPRITE_WIDTH  = 8;
   localparam int DEF_SPRITE_HEIGHT = 8;
   localparam int DEF_STROBE_PERIOD = 1000000;

endpackage

// File: rtl/game_sprite_control_if.sv
// Sprite command interface between the game master and one sprite responder.
// Carries the position/velocity commands, the raster pixel under test and
// the sprite's position/visibility reports.
interface game_sprite_control_if
   import game_sprite_control_pkg::*;
#(
   parameter int X_WIDTH = DEF_X_WIDTH,
   parameter int Y_WIDTH = DEF_Y_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH
) ();

   logic                        write_xy;
   logic signed [X_WIDTH-1:0]   write_x;
   logic signed [Y_WIDTH-1:0]   write_y;
   logic                        write_dxy;
   logic signed [D_WIDTH-1:0]   write_dx;
   logic signed [D_WIDTH-1:0]   write_dy;
   logic                        enable_update;
   logic        [X_WIDTH-1:0]   pixel_x;
   logic        [Y_WIDTH-1:0]   pixel_y;
   logic signed [X_WIDTH-1:0]   x;
   logic signed [Y_WIDTH-1:0]   y;
   logic                        within_screen;
   logic                        sprite_on;

   modport master (
      output write_xy, write_x, write_y, write_dxy, write_dx, write_dy,
             enable_update, pixel_x, pixel_y,
      input  x, y, within_screen, sprite_on
   );

   modport slave (
      input  write_xy, write_x, write_y, write_dxy, write_dx, write_dy,
             enable_update, pixel_x, pixel_y,
      output x, y, within_screen, sprite_on
   );

endinterface

// File: rtl/game_sprite_control_strobe_gen.sv
// Free-running periodic strobe: one clk-wide pulse every PERIOD cycles.
// Generic so it can also pace the end-of-game timer.
module game_strobe_gen #(
   parameter int PERIOD = 1000000
) (
   input  logic clk,
   input  logic reset,
   output logic strobe
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] count;

   // Count 0..PERIOD-1 and wrap; the pulse marks the final count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign strobe = (count == LAST);

endmodule

// File: rtl/game_sprite_control.sv
// Sprite responder: holds position and velocity, steps the position on the
// motion strobe, reports whether the sprite box overlaps the screen and flags
// raster pixels covered by the box (one clk later).
module game_sprite_control
   import game_sprite_control_pkg::*;
#(
   parameter int X_WIDTH       = DEF_X_WIDTH,
   parameter int Y_WIDTH       = DEF_Y_WIDTH,
   parameter int D_WIDTH       = DEF_D_WIDTH,
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int SPRITE_WIDTH  = DEF_SPRITE_WIDTH,
   parameter int SPRITE_HEIGHT = DEF_SPRITE_HEIGHT,
   parameter int STROBE_PERIOD = DEF_STROBE_PERIOD
) (
   input  logic                  clk,
   input  logic                  reset,
   game_sprite_control_if.slave  bus
);

   // Compares run one bit wider than the position so that x+SPRITE_WIDTH
   // and the negative screen bound cannot wrap.
   localparam logic signed [X_WIDTH:0] X_LO = (X_WIDTH + 1)'(-SPRITE_WIDTH);
   localparam logic signed [X_WIDTH:0] X_HI = (X_WIDTH + 1)'(SCREEN_WIDTH);
   localparam logic signed [X_WIDTH:0] X_SZ = (X_WIDTH + 1)'(SPRITE_WIDTH);
   localparam logic signed [Y_WIDTH:0] Y_LO = (Y_WIDTH + 1)'(-SPRITE_HEIGHT);
   localparam logic signed [Y_WIDTH:0] Y_HI = (Y_WIDTH + 1)'(SCREEN_HEIGHT);
   localparam logic signed [Y_WIDTH:0] Y_SZ = (Y_WIDTH + 1)'(SPRITE_HEIGHT);

   logic signed [X_WIDTH-1:0] x_q;
   logic signed [Y_WIDTH-1:0] y_q;
   logic signed [D_WIDTH-1:0] dx_q;
   logic signed [D_WIDTH-1:0] dy_q;
   logic                      step;
   logic                      sprite_on_q;
   logic signed [X_WIDTH:0]   xw;
   logic signed [Y_WIDTH:0]   yw;
   logic signed [X_WIDTH:0]   pxw;
   logic signed [Y_WIDTH:0]   pyw;
   logic                      hit;

   game_strobe_gen #(
      .PERIOD (STROBE_PERIOD)
   ) u_strobe (
      .clk    (clk),
      .reset  (reset),
      .strobe (step)
   );

   // Position: an explicit write beats a motion step; sums wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (bus.write_xy) begin
         x_q <= bus.write_x;
         y_q <= bus.write_y;
      end else if (step && bus.enable_update) begin
         x_q <= x_q + X_WIDTH'(dx_q);
         y_q <= y_q + Y_WIDTH'(dy_q);
      end
   end

   // Velocity: a load in a step cycle only affects later steps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dx_q <= '0;
         dy_q <= '0;
      end else if (bus.write_dxy) begin
         dx_q <= bus.write_dx;
         dy_q <= bus.write_dy;
      end
   end

   // Widened operands; raster coordinates are unsigned, so they are
   // zero-extended and a "negative" column can never fall inside the box.
   always_comb begin
      xw  = (X_WIDTH + 1)'(x_q);
      yw  = (Y_WIDTH + 1)'(y_q);
      pxw = $signed({1'b0, bus.pixel_x});
      pyw = $signed({1'b0, bus.pixel_y});
      hit = (pxw >= xw) && (pxw < xw + X_SZ) &&
            (pyw >= yw) && (pyw < yw + Y_SZ);
   end

   // Pixel coverage flag, one clk behind the raster position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sprite_on_q <= 1'b0;
      else
         sprite_on_q <= hit;
   end

   assign bus.x             = x_q;
   assign bus.y             = y_q;
   assign bus.sprite_on     = sprite_on_q;
   assign bus.within_screen = (xw > X_LO) && (xw < X_HI) &&
                              (yw > Y_LO) && (yw < Y_HI);

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench for game_sprite_control with a 4-cycle motion strobe.
module tb_game_sprite_control;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   edge_n;

   game_sprite_control_if bus ();

   game_sprite_control #(
      .STROBE_PERIOD (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n = edge_n + 1;
   endtask

   task automatic clear_cmds();
      bus.write_xy  = 1'b0;
      bus.write_dxy = 1'b0;
   endtask

   task automatic load_xy(input int nx, input int ny);
      bus.write_xy = 1'b1;
      bus.write_x  = 11'(nx);
      bus.write_y  = 10'(ny);
      tick();
      clear_cmds();
   endtask

   task automatic align_to_step();
      // leaves the bench just before an edge on which the strobe is active
      for (int i = 0; i < 4; i++)
         if (((edge_n + 1) % 4) != 0) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.write_xy = 0; bus.write_dxy = 0; bus.enable_update = 0;
      bus.write_x = 0; bus.write_y = 0; bus.write_dx = 0; bus.write_dy = 0;
      bus.pixel_x = 0; bus.pixel_y = 0;
      #3;
      checks++;
      if (bus.x !== 11'sd0 || bus.y !== 10'sd0) begin
         errors++;
         $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", bus.x, bus.y);
      end
      checks++;
      if (bus.within_screen !== 1'b1 || bus.sprite_on !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got ws=%b on=%b want 1 0", bus.within_screen, bus.sprite_on);
      end
      tick();
      tick();
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_motion();
      int n_steps;
      int step_edges[3];
      logic signed [10:0] prev_x;
      bus.write_xy  = 1; bus.write_x  = 11'sd100; bus.write_y  = 10'sd50;
      bus.write_dxy = 1; bus.write_dx = 4'sd3;    bus.write_dy = -4'sd2;
      tick();
      clear_cmds();
      bus.enable_update = 1'b1;
      n_steps = 0;
      prev_x  = bus.x;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.x !== prev_x) begin
            if (n_steps < 3) step_edges[n_steps] = edge_n;
            n_steps++;
         end
         prev_x = bus.x;
      end
      checks++;
      if (n_steps !== 3) begin
         errors++;
         $display("FAIL motion_steps: got %0d steps want 3", n_steps);
      end else begin
         checks++;
         if (step_edges[1] - step_edges[0] !== 4 || step_edges[2] - step_edges[1] !== 4) begin
            errors++;
            $display("FAIL motion_spacing: got %0d %0d want 4 4",
                     step_edges[1] - step_edges[0], step_edges[2] - step_edges[1]);
         end
      end
      checks++;
      if (bus.x !== 11'sd109 || bus.y !== 10'sd44) begin
         errors++;
         $display("FAIL motion_pos: got x=%0d y=%0d want 109 44", bus.x, bus.y);
      end
   endtask

   task automatic test_hold();
      bus.enable_update = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (bus.x !== 11'sd109 || bus.y !== 10'sd44) begin
         errors++;
         $display("FAIL hold_pos: got x=%0d y=%0d want 109 44", bus.x, bus.y);
      end
      bus.enable_update = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bus.x !== 11'sd112 || bus.y !== 10'sd42) begin
         errors++;
         $display("FAIL reenable_step: got x=%0d y=%0d want 112 42", bus.x, bus.y);
      end
   endtask

   task automatic test_within_screen();
      int   tx[6];
      int   ty[6];
      logic tw[6];
      tx = '{-7, -8,   0,   0,  5,  5};
      ty = '{100, 100, 479, 480, -7, -8};
      tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      bus.write_dxy = 1; bus.write_dx = 4'sd1; bus.write_dy = 4'sd0;
      load_xy(636, 100);
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (bus.x !== 11'sd639 || bus.within_screen !== 1'b1) begin
         errors++;
         $display("FAIL ws_639: got x=%0d ws=%b want 639 1", bus.x, bus.within_screen);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bus.x !== 11'sd640 || bus.within_screen !== 1'b0) begin
         errors++;
         $display("FAIL ws_640: got x=%0d ws=%b want 640 0", bus.x, bus.within_screen);
      end
      bus.enable_update = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load_xy(tx[i], ty[i]);
         checks++;
         if (bus.within_screen !== tw[i]) begin
            errors++;
            $display("FAIL ws_edge(%0d,%0d): got %b want %b", tx[i], ty[i], bus.within_screen, tw[i]);
         end
      end
   endtask

   task automatic test_write_priority();
      bus.write_dxy = 1; bus.write_dx = 4'sd5; bus.write_dy = 4'sd0;
      tick();
      clear_cmds();
      bus.enable_update = 1'b1;
      align_to_step();
      load_xy(10, 10);
      checks++;
      if (bus.x !== 11'sd10 || bus.y !== 10'sd10) begin
         errors++;
         $display("FAIL write_wins: got x=%0d y=%0d want 10 10", bus.x, bus.y);
      end
      align_to_step();
      tick();
      checks++;
      if (bus.x !== 11'sd15) begin
         errors++;
         $display("FAIL step_dx5: got x=%0d want 15", bus.x);
      end
      align_to_step();
      bus.write_dxy = 1; bus.write_dx = 4'sd1; bus.write_dy = 4'sd1;
      tick();
      clear_cmds();
      checks++;
      if (bus.x !== 11'sd20 || bus.y !== 10'sd10) begin
         errors++;
         $display("FAIL step_old_dxy: got x=%0d y=%0d want 20 10", bus.x, bus.y);
      end
      align_to_step();
      tick();
      checks++;
      if (bus.x !== 11'sd21 || bus.y !== 10'sd11) begin
         errors++;
         $display("FAIL step_new_dxy: got x=%0d y=%0d want 21 11", bus.x, bus.y);
      end
   endtask

   task automatic test_sprite_on();
      int   px[6];
      int   py[6];
      logic pw[6];
      px = '{20, 27, 28, 20, 19, 27};
      py = '{30, 37, 30, 38, 30, 29};
      pw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      bus.enable_update = 1'b0;
      load_xy(20, 30);
      for (int i = 0; i < 6; i++) begin
         bus.pixel_x = 11'(px[i]);
         bus.pixel_y = 10'(py[i]);
         tick();
         checks++;
         if (bus.sprite_on !== pw[i]) begin
            errors++;
            $display("FAIL sprite_on(%0d,%0d): got %b want %b", px[i], py[i], bus.sprite_on, pw[i]);
         end
      end
      load_xy(-4, 30);
      bus.pixel_x = 11'd3; bus.pixel_y = 10'd30;
      tick();
      checks++;
      if (bus.sprite_on !== 1'b1) begin
         errors++;
         $display("FAIL sprite_on_left_in: got %b want 1", bus.sprite_on);
      end
      bus.pixel_x = 11'h7FE;
      tick();
      checks++;
      if (bus.sprite_on !== 1'b0) begin
         errors++;
         $display("FAIL sprite_on_neg_px: got %b want 0", bus.sprite_on);
      end
   endtask

   task automatic test_reset_mid_motion();
      bus.enable_update = 1'b0;
      bus.pixel_x = 11'd53; bus.pixel_y = 10'd53;
      bus.write_dxy = 1; bus.write_dx = 4'sd2; bus.write_dy = 4'sd2;
      load_xy(50, 50);
      bus.enable_update = 1'b1;
      align_to_step();
      tick();
      tick();
      checks++;
      if (bus.x !== 11'sd52 || bus.sprite_on !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got x=%0d on=%b want 52 1", bus.x, bus.sprite_on);
      end
      reset = 1'b1;
      #2;
      checks++;
      if (bus.x !== 11'sd0 || bus.y !== 10'sd0 || bus.within_screen !== 1'b1 || bus.sprite_on !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got x=%0d y=%0d ws=%b on=%b want 0 0 1 0",
                  bus.x, bus.y, bus.within_screen, bus.sprite_on);
      end
      tick();
      reset  = 1'b0;
      edge_n = 0;
      bus.write_dxy = 1; bus.write_dx = 4'sd1; bus.write_dy = 4'sd1;
      tick();
      clear_cmds();
      tick();
      tick();
      checks++;
      if (bus.x !== 11'sd0) begin
         errors++;
         $display("FAIL post_reset_early: got x=%0d want 0", bus.x);
      end
      tick();
      checks++;
      if (bus.x !== 11'sd1 || bus.y !== 10'sd1) begin
         errors++;
         $display("FAIL post_reset_step: got x=%0d y=%0d want 1 1", bus.x, bus.y);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      test_reset();
      test_motion();
      test_hold();
      test_within_screen();
      test_write_priority();
      test_sprite_on();
      test_reset_mid_motion();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
